// File: rtl/hsv_core_pkg.sv
`default_nettype none
// ============================================================================
// Package : hsv_core_pkg
// Brief   : Shared core types: ALU op payload and ALU scheduler state encoding.
// Rev     : 1.0  initial release
// ============================================================================
package hsv_core_pkg;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  rd;
  } alu_data_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } alu_sched_state_t;

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hsv_core_alu_sched.sv
`default_nettype none
// ============================================================================
// Module : hsv_core_alu_sched
// Brief  : ALU pipeline sequencer: admits issue ops, drives shared stall/flush,
//          tracks in-flight ops and arbitrates against debug halt/drain.
// Rev    : 1.0  initial release
// ============================================================================
module hsv_core_alu_sched
  import hsv_core_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int FLUSH_CYC  = 2
) (
  input  logic                              clk_core,
  input  logic                              rst_core_n,
  input  logic                              flush_req,
  input  logic                              halt_req,
  output logic                              halt_ack,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  alu_data_t                         in_alu_data,
  output logic                              alu_valid_o,
  output alu_data_t                         alu_data_o,
  output logic                              alu_stall,
  output logic                              alu_flush,
  input  logic                              res_valid,
  input  logic                              out_ready,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]   in_flight
);

  localparam int                c_IF_W    = $clog2(PIPE_DEPTH + 1);
  localparam int                c_FC_W    = cnt_width(FLUSH_CYC);
  localparam logic [c_IF_W-1:0] c_DEPTH   = c_IF_W'(PIPE_DEPTH);
  localparam logic [c_IF_W-1:0] c_IF_ONE  = c_IF_W'(1);
  localparam logic [c_FC_W-1:0] c_FC_LOAD = c_FC_W'(FLUSH_CYC - 1);
  localparam logic [c_FC_W-1:0] c_FC_ONE  = c_FC_W'(1);

  alu_sched_state_t    r_state;
  alu_sched_state_t    w_state_nxt;
  logic [c_IF_W-1:0]   r_in_flight;
  logic [c_IF_W-1:0]   w_in_flight_nxt;
  logic [c_FC_W-1:0]   r_flush_cnt;
  logic [c_FC_W-1:0]   w_flush_cnt_nxt;
  logic                r_halt_ack;
  logic                w_halt_ack_nxt;
  logic                w_admit;
  logic                w_retire;

  // A result blocked at commit freezes every stage, first-stage capture included.
  assign alu_stall   = res_valid & ~out_ready;
  assign in_ready    = (r_state == RUN) & ~alu_stall & ~flush_req & ~halt_req
                     & (r_in_flight < c_DEPTH);
  assign w_admit     = in_valid & in_ready;
  assign w_retire    = res_valid & out_ready;
  assign alu_valid_o = w_admit;
  assign alu_data_o  = in_alu_data;
  assign alu_flush   = flush_req | (r_state == FLUSH);
  assign in_flight   = r_in_flight;
  assign halt_ack    = r_halt_ack;

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_halt_ack_nxt  = r_halt_ack;
    w_in_flight_nxt = r_in_flight;

    if (w_admit && !w_retire) begin
      w_in_flight_nxt = r_in_flight + c_IF_ONE;
    end else if (!w_admit && w_retire) begin
      w_in_flight_nxt = r_in_flight - c_IF_ONE;
    end

    // Flush outranks everything, including a stalled pipe and in-cycle admit/retire.
    if (flush_req) begin
      w_state_nxt     = FLUSH;
      w_flush_cnt_nxt = c_FC_LOAD;
      w_in_flight_nxt = '0;
      w_halt_ack_nxt  = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (halt_req) begin
            w_state_nxt = DRAIN;
          end
        end
        FLUSH: begin
          w_in_flight_nxt = '0;
          if (r_flush_cnt == '0) begin
            w_state_nxt = halt_req ? DRAIN : RUN;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - c_FC_ONE;
          end
        end
        DRAIN: begin
          if (!halt_req) begin
            w_state_nxt = RUN;
          end else if (w_in_flight_nxt == '0) begin
            w_state_nxt    = HALTED;
            w_halt_ack_nxt = 1'b1;
          end
        end
        HALTED: begin
          if (!halt_req) begin
            w_state_nxt    = RUN;
            w_halt_ack_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_state     <= RUN;
      r_in_flight <= '0;
      r_flush_cnt <= '0;
      r_halt_ack  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_flight <= w_in_flight_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_halt_ack  <= w_halt_ack_nxt;
    end
  end

  a_in_flight_bound: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    r_in_flight <= c_DEPTH);

  a_no_underflow: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    !(w_retire && !w_admit && !flush_req && (r_state != FLUSH) && (r_in_flight == '0)));

  a_admit_only_in_run: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    !(w_admit && (r_state != RUN)));

  a_halt_drained: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    r_halt_ack |-> (r_in_flight == '0));

endmodule
`default_nettype wire

// File: tb/tb_hsv_core_alu_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_hsv_core_alu_sched
// Brief  : Scoreboard bench for hsv_core_alu_sched with a 3-stage ALU stand-in.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hsv_core_alu_sched;
  import hsv_core_pkg::*;

  localparam int PD      = 3;
  localparam int FC      = 2;
  localparam int S_RUN   = 0;
  localparam int S_FLUSH = 1;
  localparam int S_DRAIN = 2;
  localparam int S_HALT  = 3;

  logic       clk_core = 1'b0;
  logic       rst_core_n;
  logic       flush_req, halt_req, halt_ack;
  logic       in_valid, in_ready, alu_valid_o, alu_stall, alu_flush;
  logic       res_valid, out_ready;
  logic [1:0] in_flight;
  alu_data_t  in_alu_data, alu_data_o;

  int n_chk  = 0;
  int n_pass = 0;

  hsv_core_alu_sched #(.PIPE_DEPTH(PD), .FLUSH_CYC(FC)) dut (
    .clk_core    (clk_core),
    .rst_core_n  (rst_core_n),
    .flush_req   (flush_req),
    .halt_req    (halt_req),
    .halt_ack    (halt_ack),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_alu_data (in_alu_data),
    .alu_valid_o (alu_valid_o),
    .alu_data_o  (alu_data_o),
    .alu_stall   (alu_stall),
    .alu_flush   (alu_flush),
    .res_valid   (res_valid),
    .out_ready   (out_ready),
    .in_flight   (in_flight)
  );

  always #5 clk_core = ~clk_core;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Three-stage ALU stand-in honouring the shared stall/flush.
  logic [2:0] pv;
  alu_data_t  pd [0:2];
  assign res_valid = pv[2];

  always @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      pv <= '0;
    end else if (alu_flush) begin
      pv <= '0;
    end else if (!alu_stall) begin
      pv    <= {pv[1], pv[0], alu_valid_o};
      pd[2] <= pd[1];
      pd[1] <= pd[0];
      pd[0] <= alu_data_o;
    end
  end

  // Reference model of the sequencer.
  int   m_st, m_if, m_cnt;
  logic m_ack;
  logic e_stall, e_ready, e_admit, e_retire, e_flush;
  int   e_drain_if;

  assign e_stall    = res_valid & ~out_ready;
  assign e_ready    = (m_st == S_RUN) && !e_stall && !flush_req && !halt_req && (m_if < PD);
  assign e_admit    = in_valid & e_ready;
  assign e_retire   = res_valid & out_ready;
  assign e_flush    = flush_req | (m_st == S_FLUSH);
  assign e_drain_if = m_if - (e_retire ? 1 : 0);

  always @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      m_st <= S_RUN; m_if <= 0; m_cnt <= 0; m_ack <= 1'b0;
    end else if (flush_req) begin
      m_st <= S_FLUSH; m_cnt <= FC - 1; m_if <= 0; m_ack <= 1'b0;
    end else begin
      case (m_st)
        S_RUN: begin
          m_if <= m_if + (e_admit ? 1 : 0) - (e_retire ? 1 : 0);
          if (halt_req) m_st <= S_DRAIN;
        end
        S_FLUSH: begin
          m_if <= 0;
          if (m_cnt == 0) m_st <= halt_req ? S_DRAIN : S_RUN;
          else            m_cnt <= m_cnt - 1;
        end
        S_DRAIN: begin
          m_if <= e_drain_if;
          if (!halt_req) m_st <= S_RUN;
          else if (e_drain_if == 0) begin m_st <= S_HALT; m_ack <= 1'b1; end
        end
        default: begin
          if (!halt_req) begin m_st <= S_RUN; m_ack <= 1'b0; end
        end
      endcase
    end
  end

  // Scoreboard: push stimulus payload on expected admit, pop on retire.
  alu_data_t sb_q [$];
  alu_data_t sb_exp;

  always @(negedge rst_core_n) sb_q.delete();

  always @(negedge clk_core) begin
    if (rst_core_n) begin
      check("in_ready",  128'(in_ready),    128'(e_ready));
      check("alu_valid", 128'(alu_valid_o), 128'(e_admit));
      check("alu_stall", 128'(alu_stall),   128'(e_stall));
      check("alu_flush", 128'(alu_flush),   128'(e_flush));
      check("in_flight", 128'(in_flight),   128'(m_if));
      check("halt_ack",  128'(halt_ack),    128'(m_ack));
      check("alu_data",  128'(alu_data_o),  128'(in_alu_data));
      if (e_retire) begin
        if (sb_q.size() == 0) begin
          check("sb_underrun", 128'(1), 128'(0));
        end else begin
          sb_exp = sb_q.pop_front();
          check("result", 128'(pd[2]), 128'(sb_exp));
        end
      end
      if (e_admit) sb_q.push_back(in_alu_data);
      if (e_flush) sb_q.delete();
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_core);
      #1;
    end
  endtask

  task automatic rnd_data();
    in_alu_data.op    = 4'($urandom);
    in_alu_data.src_a = $urandom;
    in_alu_data.src_b = $urandom;
    in_alu_data.rd    = 5'($urandom);
  endtask

  int snap;

  initial begin
    rst_core_n = 1'b0;
    in_valid = 1'b0; flush_req = 1'b0; halt_req = 1'b0; out_ready = 1'b1;
    rnd_data();
    #2;
    check("rst_if_held",  128'(in_flight), 128'(0));
    check("rst_ack_held", 128'(halt_ack),  128'(0));
    cyc(2);
    rst_core_n = 1'b1;
    #2;
    check("rst_if",    128'(in_flight), 128'(0));
    check("rst_ready", 128'(in_ready),  128'(1));
    check("rst_flush", 128'(alu_flush), 128'(0));

    // Back-to-back admits with commit always ready
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      rnd_data();
      #2 check("b2b_if", 128'(in_flight), 128'(i + 1));
    end
    check("b2b_full_ready", 128'(in_ready), 128'(0));
    for (int i = 0; i < 8; i++) begin cyc(); rnd_data(); end

    // Commit back-pressure
    in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 8 && !res_valid; k++) cyc();
    #1;
    check("stall_hi",    128'(alu_stall), 128'(1));
    check("stall_ready", 128'(in_ready),  128'(0));
    snap = int'(in_flight);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_frozen", 128'(in_flight), 128'(snap));
    end
    out_ready = 1'b1;
    cyc();
    #1 check("stall_release", 128'(in_flight), 128'(snap - 1));
    cyc(6);

    // Flush with a full pipe
    in_valid = 1'b1; out_ready = 1'b0;
    cyc(3);
    in_valid = 1'b0;
    #1 check("fl_full", 128'(in_flight), 128'(3));
    flush_req = 1'b1;
    #1 check("fl_c0_flush", 128'(alu_flush), 128'(1));
    check("fl_c0_ready", 128'(in_ready), 128'(0));
    cyc();
    flush_req = 1'b0;
    #2 check("fl_c1_if", 128'(in_flight), 128'(0));
    check("fl_c1_flush", 128'(alu_flush), 128'(1));
    check("fl_c1_ready", 128'(in_ready),  128'(0));
    cyc();
    #2 check("fl_c2_flush", 128'(alu_flush), 128'(1));
    check("fl_c2_ready", 128'(in_ready), 128'(0));
    cyc();
    #2 check("fl_done_flush", 128'(alu_flush), 128'(0));
    check("fl_done_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;

    // Two ops parked at the end, then admit+retire together
    in_valid = 1'b1; out_ready = 1'b0;
    cyc(2);
    in_valid = 1'b0;
    cyc(2);
    #1 check("ar_if_pre", 128'(in_flight), 128'(2));
    check("ar_stall", 128'(alu_stall), 128'(1));
    in_valid = 1'b1; out_ready = 1'b1; rnd_data();
    cyc();
    #1 check("ar_if_post", 128'(in_flight), 128'(2));

    // Halt with two in flight: drain, ack, release
    in_valid = 1'b0; halt_req = 1'b1;
    for (int k = 0; k < 12 && !halt_ack; k++) cyc();
    #1 check("halt_ack", 128'(halt_ack), 128'(1));
    check("halt_if",    128'(in_flight), 128'(0));
    check("halt_ready", 128'(in_ready),  128'(0));
    halt_req = 1'b0;
    cyc();
    #1 check("unhalt_ack", 128'(halt_ack), 128'(0));
    check("unhalt_ready", 128'(in_ready), 128'(1));

    // Flush and halt together: flush wins, then drain to halt
    flush_req = 1'b1; halt_req = 1'b1;
    #1 check("fh_flush", 128'(alu_flush), 128'(1));
    cyc();
    flush_req = 1'b0;
    #1 check("fh_flush_state", 128'(alu_flush), 128'(1));
    check("fh_ack_low", 128'(halt_ack), 128'(0));
    for (int k = 0; k < 12 && !halt_ack; k++) cyc();
    #1 check("fh_halted", 128'(halt_ack), 128'(1));
    halt_req = 1'b0;
    cyc(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      flush_req = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
      rnd_data();
      cyc();
    end
    in_valid = 1'b0; flush_req = 1'b0; halt_req = 1'b0; out_ready = 1'b1;
    cyc(3);

    // Asynchronous reset in the middle of traffic
    in_valid = 1'b1;
    cyc(4);
    #2 rst_core_n = 1'b0;
    #1 check("arst_if", 128'(in_flight), 128'(0));
    check("arst_ack",   128'(halt_ack),  128'(0));
    check("arst_stall", 128'(alu_stall), 128'(0));
    in_valid = 1'b0;
    cyc();
    rst_core_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("post_rst_if",  128'(in_flight), 128'(0));
      check("post_rst_res", 128'(res_valid), 128'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
